// File: rtl/glb_fps_port.sv
// Global-buffer port for the FPS engine: coordinate reads and distance read/write
// traffic. Each read path returns data through its own 3-deep output FIFO.

module glb_fps_rdchan #(
    parameter int DW = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          issue,
    input  logic [DW-1:0] sramDat,
    input  logic          popRdy,
    output logic          spaceAvail,
    output logic          headVld,
    output logic [DW-1:0] headDat
);
    localparam int DEPTH = 3;

    logic [DW-1:0] mem_r [DEPTH];
    logic [1:0]    wrPtr_r;
    logic [1:0]    rdPtr_r;
    logic [1:0]    count_r;
    logic          inflight_r;
    logic          push_s;
    logic          pop_s;
    logic [2:0]    occ_s;
    logic [1:0]    countNext_s;

    function automatic logic [1:0] ptrInc(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Occupancy counts the read still in the SRAM pipe, so the FIFO can never overflow.
    always_comb begin
        occ_s       = {1'b0, count_r} + {2'b00, inflight_r};
        spaceAvail  = (occ_s < 3'd3);
        headVld     = (count_r != 2'd0);
        headDat     = mem_r[rdPtr_r];
        push_s      = inflight_r & ~flush;
        pop_s       = headVld & popRdy & ~flush;
        case ({push_s, pop_s})
            2'b10:   countNext_s = count_r + 2'd1;
            2'b01:   countNext_s = count_r - 2'd1;
            default: countNext_s = count_r;
        endcase
    end

    // FIFO storage, pointers, count and in-flight flag; flush drops returning data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
            wrPtr_r    <= 2'd0;
            rdPtr_r    <= 2'd0;
            count_r    <= 2'd0;
            inflight_r <= 1'b0;
        end else if (flush) begin
            wrPtr_r    <= 2'd0;
            rdPtr_r    <= 2'd0;
            count_r    <= 2'd0;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue;
            count_r    <= countNext_s;
            if (push_s) begin
                mem_r[wrPtr_r] <= sramDat;
                wrPtr_r        <= ptrInc(wrPtr_r);
            end
            if (pop_s) begin
                rdPtr_r <= ptrInc(rdPtr_r);
            end
        end
    end
endmodule

module glb_fps_port #(
    parameter int SRAM_WIDTH    = 256,
    parameter int IDX_WIDTH     = 10,
    parameter int DISTSQR_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             CCUCTR_Rst,
    input  logic [IDX_WIDTH-1:0]             FPSGLB_CrdAddr,
    input  logic                             FPSGLB_CrdAddrVld,
    output logic                             GLBFPS_CrdAddrRdy,
    output logic [SRAM_WIDTH-1:0]            GLBFPS_Crd,
    output logic                             GLBFPS_CrdVld,
    input  logic                             FPSGLB_CrdRdy,
    input  logic [IDX_WIDTH-1:0]             CTRGLB_DistRdAddr,
    input  logic                             CTRGLB_DistRdAddrVld,
    output logic                             GLBCTR_DistRdAddrRdy,
    output logic [DISTSQR_WIDTH+IDX_WIDTH-1:0] GLBCTR_DistIdx,
    output logic                             GLBCTR_DistIdxVld,
    input  logic                             CTRGLB_DistIdxRdy,
    input  logic [IDX_WIDTH-1:0]             CTRGLB_DistWrAddr,
    input  logic [DISTSQR_WIDTH+IDX_WIDTH-1:0] CTRGLB_DistIdx,
    input  logic                             CTRGLB_DistIdxVld,
    output logic                             GLBCTR_DistIdxRdy,
    output logic                             CrdSram_RdEn,
    output logic [IDX_WIDTH-1:0]             CrdSram_Addr,
    input  logic [SRAM_WIDTH-1:0]            CrdSram_RdDat,
    output logic                             DistSram_En,
    output logic                             DistSram_We,
    output logic [IDX_WIDTH-1:0]             DistSram_Addr,
    output logic [DISTSQR_WIDTH+IDX_WIDTH-1:0] DistSram_WrDat,
    input  logic [DISTSQR_WIDTH+IDX_WIDTH-1:0] DistSram_RdDat
);
    localparam int DIW = DISTSQR_WIDTH + IDX_WIDTH;

    logic crdSpace_s;
    logic crdIssue_s;
    logic distSpace_s;
    logic distIssue_s;
    logic distWr_s;

    // Handshake decode; a pending write blocks the distance read port for that cycle.
    always_comb begin
        GLBFPS_CrdAddrRdy    = crdSpace_s & ~CCUCTR_Rst;
        crdIssue_s           = FPSGLB_CrdAddrVld & GLBFPS_CrdAddrRdy;
        GLBCTR_DistIdxRdy    = ~CCUCTR_Rst;
        distWr_s             = CTRGLB_DistIdxVld & GLBCTR_DistIdxRdy;
        GLBCTR_DistRdAddrRdy = distSpace_s & ~CTRGLB_DistIdxVld & ~CCUCTR_Rst;
        distIssue_s          = CTRGLB_DistRdAddrVld & GLBCTR_DistRdAddrRdy;
    end

    // Coordinate SRAM request, driven in the handshake cycle.
    always_comb begin
        CrdSram_RdEn = crdIssue_s;
        if (crdIssue_s) begin
            CrdSram_Addr = FPSGLB_CrdAddr;
        end else begin
            CrdSram_Addr = {IDX_WIDTH{1'b0}};
        end
    end

    // Distance SRAM port shared by write and read, write first.
    always_comb begin
        DistSram_En    = 1'b0;
        DistSram_We    = 1'b0;
        DistSram_Addr  = {IDX_WIDTH{1'b0}};
        DistSram_WrDat = {DIW{1'b0}};
        if (distWr_s) begin
            DistSram_En    = 1'b1;
            DistSram_We    = 1'b1;
            DistSram_Addr  = CTRGLB_DistWrAddr;
            DistSram_WrDat = CTRGLB_DistIdx;
        end else if (distIssue_s) begin
            DistSram_En   = 1'b1;
            DistSram_Addr = CTRGLB_DistRdAddr;
        end else begin
            DistSram_En = 1'b0;
        end
    end

    glb_fps_rdchan #(.DW(SRAM_WIDTH)) uCrdChan (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (CCUCTR_Rst),
        .issue      (crdIssue_s),
        .sramDat    (CrdSram_RdDat),
        .popRdy     (FPSGLB_CrdRdy),
        .spaceAvail (crdSpace_s),
        .headVld    (GLBFPS_CrdVld),
        .headDat    (GLBFPS_Crd)
    );

    glb_fps_rdchan #(.DW(DIW)) uDistChan (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (CCUCTR_Rst),
        .issue      (distIssue_s),
        .sramDat    (DistSram_RdDat),
        .popRdy     (CTRGLB_DistIdxRdy),
        .spaceAvail (distSpace_s),
        .headVld    (GLBCTR_DistIdxVld),
        .headDat    (GLBCTR_DistIdx)
    );
endmodule

// File: tb/tb_glb_fps_port.sv
// Self-checking bench for glb_fps_port: SRAM models plus a transaction-level
// reference (outstanding-request queues and a distance memory image).

module tb_glb_fps_port;
    localparam int SW  = 256;
    localparam int IW  = 10;
    localparam int DSW = 16;
    localparam int DIW = DSW + IW;

    logic clk = 1'b0;
    logic rst_n;
    logic CCUCTR_Rst;
    logic [IW-1:0]  FPSGLB_CrdAddr;
    logic           FPSGLB_CrdAddrVld;
    logic           GLBFPS_CrdAddrRdy;
    logic [SW-1:0]  GLBFPS_Crd;
    logic           GLBFPS_CrdVld;
    logic           FPSGLB_CrdRdy;
    logic [IW-1:0]  CTRGLB_DistRdAddr;
    logic           CTRGLB_DistRdAddrVld;
    logic           GLBCTR_DistRdAddrRdy;
    logic [DIW-1:0] GLBCTR_DistIdx;
    logic           GLBCTR_DistIdxVld;
    logic           CTRGLB_DistIdxRdy;
    logic [IW-1:0]  CTRGLB_DistWrAddr;
    logic [DIW-1:0] CTRGLB_DistIdx;
    logic           CTRGLB_DistIdxVld;
    logic           GLBCTR_DistIdxRdy;
    logic           CrdSram_RdEn;
    logic [IW-1:0]  CrdSram_Addr;
    logic [SW-1:0]  CrdSram_RdDat;
    logic           DistSram_En;
    logic           DistSram_We;
    logic [IW-1:0]  DistSram_Addr;
    logic [DIW-1:0] DistSram_WrDat;
    logic [DIW-1:0] DistSram_RdDat;

    glb_fps_port #(.SRAM_WIDTH(SW), .IDX_WIDTH(IW), .DISTSQR_WIDTH(DSW)) dut (
        .clk(clk), .rst_n(rst_n), .CCUCTR_Rst(CCUCTR_Rst),
        .FPSGLB_CrdAddr(FPSGLB_CrdAddr), .FPSGLB_CrdAddrVld(FPSGLB_CrdAddrVld),
        .GLBFPS_CrdAddrRdy(GLBFPS_CrdAddrRdy), .GLBFPS_Crd(GLBFPS_Crd),
        .GLBFPS_CrdVld(GLBFPS_CrdVld), .FPSGLB_CrdRdy(FPSGLB_CrdRdy),
        .CTRGLB_DistRdAddr(CTRGLB_DistRdAddr), .CTRGLB_DistRdAddrVld(CTRGLB_DistRdAddrVld),
        .GLBCTR_DistRdAddrRdy(GLBCTR_DistRdAddrRdy), .GLBCTR_DistIdx(GLBCTR_DistIdx),
        .GLBCTR_DistIdxVld(GLBCTR_DistIdxVld), .CTRGLB_DistIdxRdy(CTRGLB_DistIdxRdy),
        .CTRGLB_DistWrAddr(CTRGLB_DistWrAddr), .CTRGLB_DistIdx(CTRGLB_DistIdx),
        .CTRGLB_DistIdxVld(CTRGLB_DistIdxVld), .GLBCTR_DistIdxRdy(GLBCTR_DistIdxRdy),
        .CrdSram_RdEn(CrdSram_RdEn), .CrdSram_Addr(CrdSram_Addr), .CrdSram_RdDat(CrdSram_RdDat),
        .DistSram_En(DistSram_En), .DistSram_We(DistSram_We), .DistSram_Addr(DistSram_Addr),
        .DistSram_WrDat(DistSram_WrDat), .DistSram_RdDat(DistSram_RdDat)
    );

    always #5 clk = ~clk;

    function automatic logic [SW-1:0] crdWord(input logic [IW-1:0] a);
        logic [31:0] x;
        x = (32'h9E37_79B9 * ({22'd0, a} + 32'd1)) ^ {a, 22'd0};
        return {8{x}};
    endfunction

    function automatic logic [DIW-1:0] distSeed(input int i);
        logic [15:0] d;
        d = 16'(i * 37 + 5);
        return {d, 10'(i)};
    endfunction

    // Coordinate SRAM: one-cycle read latency
    always @(posedge clk) begin
        if (CrdSram_RdEn) CrdSram_RdDat <= crdWord(CrdSram_Addr);
    end

    // Distance SRAM: one-cycle read latency, preloaded once
    logic [DIW-1:0] distSram [1024];
    bit envInit = 1'b0;
    always @(posedge clk) begin
        if (!envInit) begin
            for (int i = 0; i < 1024; i++) distSram[i] <= distSeed(i);
            envInit <= 1'b1;
        end else if (DistSram_En) begin
            if (DistSram_We) distSram[DistSram_Addr] <= DistSram_WrDat;
            else             DistSram_RdDat <= distSram[DistSram_Addr];
        end
    end

    // Reference model: accepted-but-not-consumed requests with their expected data
    typedef struct { logic [SW-1:0] dat; int t; } ent_t;
    ent_t crdQ[$];
    ent_t distQ[$];
    logic [DIW-1:0] refDist [1024];
    int cyc = 0;
    int errCnt = 0;
    int chkCnt = 0;

    task automatic checkEq(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic idle();
        CCUCTR_Rst = 1'b0;
        FPSGLB_CrdAddrVld = 1'b0;
        FPSGLB_CrdRdy = 1'b1;
        CTRGLB_DistRdAddrVld = 1'b0;
        CTRGLB_DistIdxRdy = 1'b1;
        CTRGLB_DistIdxVld = 1'b0;
    endtask

    task automatic step();
        bit flush, crdAcc, wrAcc, rdAcc, expCrdVld, expDistVld, expCrdRdy, expRdRdy;
        ent_t e;
        @(negedge clk);
        flush     = CCUCTR_Rst;
        expCrdRdy = !flush && (crdQ.size() < 3);
        expRdRdy  = !flush && !CTRGLB_DistIdxVld && (distQ.size() < 3);
        crdAcc    = FPSGLB_CrdAddrVld && expCrdRdy;
        wrAcc     = CTRGLB_DistIdxVld && !flush;
        rdAcc     = CTRGLB_DistRdAddrVld && expRdRdy;
        expCrdVld  = (crdQ.size() > 0) && (crdQ[0].t + 2 <= cyc);
        expDistVld = (distQ.size() > 0) && (distQ[0].t + 2 <= cyc);

        checkEq("crdAddrRdy", SW'(GLBFPS_CrdAddrRdy), SW'(expCrdRdy));
        checkEq("distRdRdy", SW'(GLBCTR_DistRdAddrRdy), SW'(expRdRdy));
        checkEq("distWrRdy", SW'(GLBCTR_DistIdxRdy), SW'(!flush));
        checkEq("crdRdEn", SW'(CrdSram_RdEn), SW'(crdAcc));
        if (crdAcc) checkEq("crdSramAddr", SW'(CrdSram_Addr), SW'(FPSGLB_CrdAddr));
        checkEq("distEn", SW'(DistSram_En), SW'(wrAcc || rdAcc));
        checkEq("distWe", SW'(DistSram_We), SW'(wrAcc));
        if (wrAcc) begin
            checkEq("distWrAddr", SW'(DistSram_Addr), SW'(CTRGLB_DistWrAddr));
            checkEq("distWrDat", SW'(DistSram_WrDat), SW'(CTRGLB_DistIdx));
        end else if (rdAcc) begin
            checkEq("distRdAddr", SW'(DistSram_Addr), SW'(CTRGLB_DistRdAddr));
        end
        checkEq("crdVld", SW'(GLBFPS_CrdVld), SW'(expCrdVld));
        if (expCrdVld) checkEq("crdData", GLBFPS_Crd, crdQ[0].dat);
        checkEq("distVld", SW'(GLBCTR_DistIdxVld), SW'(expDistVld));
        if (expDistVld) checkEq("distData", SW'(GLBCTR_DistIdx), distQ[0].dat);

        if (!flush && expCrdVld && FPSGLB_CrdRdy) void'(crdQ.pop_front());
        if (!flush && expDistVld && CTRGLB_DistIdxRdy) void'(distQ.pop_front());
        if (crdAcc) begin
            e.dat = crdWord(FPSGLB_CrdAddr); e.t = cyc; crdQ.push_back(e);
        end
        if (rdAcc) begin
            e.dat = SW'(refDist[CTRGLB_DistRdAddr]); e.t = cyc; distQ.push_back(e);
        end
        if (wrAcc) refDist[CTRGLB_DistWrAddr] = CTRGLB_DistIdx;
        if (flush) begin
            crdQ.delete();
            distQ.delete();
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int rdyPct;
        for (int i = 0; i < 1024; i++) refDist[i] = distSeed(i);
        rst_n = 1'b0;
        idle();
        FPSGLB_CrdAddr = '0;
        CTRGLB_DistRdAddr = '0;
        CTRGLB_DistWrAddr = '0;
        CTRGLB_DistIdx = '0;
        repeat (2) begin
            @(negedge clk);
            checkEq("rstCrdVld", SW'(GLBFPS_CrdVld), '0);
            checkEq("rstDistVld", SW'(GLBCTR_DistIdxVld), '0);
            checkEq("rstRdEn", SW'(CrdSram_RdEn), '0);
            checkEq("rstDistEn", SW'(DistSram_En), '0);
            checkEq("rstDistWe", SW'(DistSram_We), '0);
            checkEq("rstCrd", GLBFPS_Crd, '0);
            checkEq("rstDistIdx", SW'(GLBCTR_DistIdx), '0);
            checkEq("rstWrDat", SW'(DistSram_WrDat), '0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // single read of address 5, latency 2
        idle(); FPSGLB_CrdAddrVld = 1'b1; FPSGLB_CrdAddr = 10'd5; step();
        idle(); repeat (3) step();

        // addresses 0..9 back to back
        for (int i = 0; i < 10; i++) begin
            FPSGLB_CrdAddrVld = 1'b1; FPSGLB_CrdAddr = 10'(i); step();
        end
        idle(); repeat (4) step();

        // consumer stalled: only three accepted, then drained in order
        FPSGLB_CrdRdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            FPSGLB_CrdAddrVld = 1'b1; FPSGLB_CrdAddr = 10'(20 + i); step();
        end
        idle(); repeat (5) step();

        // write and read of address 7 in the same cycle
        CTRGLB_DistIdxVld = 1'b1; CTRGLB_DistWrAddr = 10'd7; CTRGLB_DistIdx = {16'h00A0, 10'd7};
        CTRGLB_DistRdAddrVld = 1'b1; CTRGLB_DistRdAddr = 10'd7; step();
        CTRGLB_DistIdxVld = 1'b0; step();
        idle(); repeat (3) step();

        // flush with one read in flight and two entries queued on both channels
        FPSGLB_CrdRdy = 1'b0; CTRGLB_DistIdxRdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            FPSGLB_CrdAddrVld = 1'b1; FPSGLB_CrdAddr = 10'(40 + i);
            CTRGLB_DistRdAddrVld = 1'b1; CTRGLB_DistRdAddr = 10'(40 + i); step();
        end
        idle(); CCUCTR_Rst = 1'b1; step();
        idle(); repeat (4) step();

        // randomized traffic on all three channels
        rdyPct = 75;
        for (int n = 0; n < 3000; n++) begin
            if (n % 400 == 0) rdyPct = $urandom_range(10, 100);
            CCUCTR_Rst           = ($urandom_range(0, 63) == 0);
            FPSGLB_CrdAddrVld    = ($urandom_range(0, 3) != 0);
            FPSGLB_CrdAddr       = 10'($urandom_range(0, 1023));
            FPSGLB_CrdRdy        = ($urandom_range(1, 100) <= rdyPct);
            CTRGLB_DistRdAddrVld = ($urandom_range(0, 2) != 0);
            CTRGLB_DistRdAddr    = 10'($urandom_range(0, 15));
            CTRGLB_DistIdxRdy    = ($urandom_range(1, 100) <= 100 - rdyPct / 2);
            CTRGLB_DistIdxVld    = ($urandom_range(0, 3) == 0);
            CTRGLB_DistWrAddr    = 10'($urandom_range(0, 15));
            CTRGLB_DistIdx       = DIW'($urandom);
            step();
        end
        idle(); repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end
endmodule
